pcie_tx_source: RTL and testbench

Transmit-side source that feeds the interconnect's main FIFO. It accepts 6-bit words from a host over a valid/ready handshake and buffers them in a small internal queue. It drives `data_in`/`push_data_in` of the interconnect and stops pushing when the main FIFO raises `MAIN_FIFO_pause`. It also keeps per-virtual-channel push counters for the bench and status logic.

---
 rtl/pcie_tx_source.sv | 140 ++++++++++++++
 tb/tb_pcie_tx_source.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_source.sv
// pcie_tx_source
//   Transmit-side source feeding the interconnect's main FIFO. Host words are
//   accepted over a valid/ready handshake into a small circular queue and
//   pushed out one per cycle unless the main FIFO signals pause. Per-VC push
//   counters (saturating) are kept for status logic.
//
// Ports:
//   clk         - single clock, rising edge
//   reset_L     - asynchronous active-low reset
//   init        - synchronous flush (queue, counters, FSM)
//   src_valid   - host offers src_data
//   src_data    - host word: [5]=VC, [4]=destination, [3:0]=payload
//   src_ready   - queue can accept a word (!full && !init)
//   main_pause  - main FIFO almost_full; suppresses pushes
//   data_out    - registered word to interconnect data_in
//   push_out    - registered one-cycle push strobe per word
//   cnt_vc0     - saturating count of pushed VC0 words
//   cnt_vc1     - saturating count of pushed VC1 words
//   busy        - FSM is not IDLE
module pcie_tx_source #(
  parameter int WORD_SIZE = 6,
  parameter int DEPTH     = 4,
  parameter int PTR_L     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic                 src_valid,
  input  logic [WORD_SIZE-1:0] src_data,
  output logic                 src_ready,
  input  logic                 main_pause,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 push_out,
  output logic [CNT_W-1:0]     cnt_vc0,
  output logic [CNT_W-1:0]     cnt_vc1,
  output logic                 busy
);

  localparam int CW = PTR_L + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t               state, state_next;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [PTR_L-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_next;
  logic                 full, empty, wr_en, rd_en;
  logic [WORD_SIZE-1:0] head;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign src_ready = !full && !init;
  assign wr_en     = src_valid && src_ready;
  // The push decision uses the occupancy before this edge's write, so a word
  // written now only becomes pushable at the following edge.
  assign rd_en     = !empty && !main_pause && !init;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE);

  // Occupancy after this edge, used to pick the next FSM state.
  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_next;
  end

  // Next state follows next-cycle occupancy and the current pause level.
  always_comb begin
    state_next = state;
    if (init)                   state_next = IDLE;
    else if (count_next == '0)  state_next = IDLE;
    else if (main_pause)        state_next = HOLD;
    else                        state_next = SEND;
  end

  // Queue storage; contents need no reset since pointers/count gate them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= src_data;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Registered push interface; data_out holds its value between pushes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      push_out <= 1'b0;
    end else if (init) begin
      data_out <= '0;
      push_out <= 1'b0;
    end else begin
      push_out <= rd_en;
      if (rd_en) data_out <= head;
    end
  end

  // Per-VC saturating push counters keyed on the VC bit of the pushed word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else if (init) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else if (rd_en) begin
      if (head[WORD_SIZE-1]) begin
        if (cnt_vc1 != '1) cnt_vc1 <= cnt_vc1 + 1'b1;
      end else begin
        if (cnt_vc0 != '1) cnt_vc0 <= cnt_vc0 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tx_source.sv
// tb_pcie_tx_source
//   Directed bench for pcie_tx_source. A main instance (CNT_W=8) covers reset,
//   single-word latency, backpressure, pause toggling and flush; a second
//   instance (CNT_W=3) covers counter saturation.
module tb_pcie_tx_source;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       init = 1'b0;
  logic       src_valid = 1'b0;
  logic [5:0] src_data = '0;
  logic       src_ready;
  logic       main_pause = 1'b0;
  logic [5:0] data_out;
  logic       push_out;
  logic [7:0] cnt_vc0, cnt_vc1;
  logic       busy;

  logic       sat_init = 1'b0;
  logic       sat_valid = 1'b0;
  logic [5:0] sat_data = '0;
  logic       sat_ready;
  logic       sat_pause = 1'b0;
  logic [5:0] sat_dout;
  logic       sat_push;
  logic [2:0] sat_cnt_vc0, sat_cnt_vc1;
  logic       sat_busy;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  pcie_tx_source #(.WORD_SIZE(6), .DEPTH(4), .PTR_L(2), .CNT_W(8)) u_dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .main_pause(main_pause), .data_out(data_out), .push_out(push_out),
    .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1), .busy(busy)
  );

  pcie_tx_source #(.WORD_SIZE(6), .DEPTH(4), .PTR_L(2), .CNT_W(3)) u_sat (
    .clk(clk), .reset_L(reset_L), .init(sat_init),
    .src_valid(sat_valid), .src_data(sat_data), .src_ready(sat_ready),
    .main_pause(sat_pause), .data_out(sat_dout), .push_out(sat_push),
    .cnt_vc0(sat_cnt_vc0), .cnt_vc1(sat_cnt_vc1), .busy(sat_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle, then release.
  task automatic test_reset();
    #2 reset_L = 1'b0;
    #1;
    n_compared++;
    if (push_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_push: got %b expected 0", push_out); end
    n_compared++;
    if (data_out !== 6'h00) begin n_mismatched++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
    n_compared++;
    if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tick();
    tick();
    #3 reset_L = 1'b1;
    tick();
    n_compared++;
    if (src_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", src_ready); end
  endtask

  // One VC1 word: push one edge after acceptance, single-cycle strobe.
  task automatic test_single_word();
    src_valid = 1'b1;
    src_data  = 6'b10_1010;
    tick();
    src_valid = 1'b0;
    n_compared++;
    if (push_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_no_writethrough: got %b expected 0", push_out); end
    n_compared++;
    if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    tick();
    n_compared++;
    if (push_out !== 1'b1 || data_out !== 6'h2A) begin n_mismatched++; $display("[TB] FAIL single_push: got %b/%h expected 1/2a", push_out, data_out); end
    tick();
    n_compared++;
    if (push_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_pulse_end: got %b expected 0", push_out); end
    n_compared++;
    if (cnt_vc1 !== 8'd1 || cnt_vc0 !== 8'd0) begin n_mismatched++; $display("[TB] FAIL single_cnt: got %0d/%0d expected vc0=0 vc1=1", cnt_vc0, cnt_vc1); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
  endtask

  // Fill under pause, then drain 0x01..0x05 on consecutive cycles.
  task automatic test_backpressure();
    main_pause = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      src_valid = 1'b1;
      src_data  = 6'(i);
      n_compared++;
      if (src_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_ready_%0d: got %b expected 1", i, src_ready); end
      tick();
      n_compared++;
      if (push_out !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_hold_%0d: got push=%b busy=%b expected push=0 busy=1", i, push_out, busy); end
    end
    src_data = 6'h05;
    n_compared++;
    if (src_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_full: got %b expected 0", src_ready); end
    tick();
    n_compared++;
    if (push_out !== 1'b0 || src_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_full_hold: got push=%b ready=%b expected 0/0", push_out, src_ready); end
    main_pause = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_compared++;
      if (push_out !== 1'b1 || data_out !== 6'(k + 1)) begin n_mismatched++; $display("[TB] FAIL bp_drain_%0d: got %b/%h expected 1/%h", k, push_out, data_out, 6'(k + 1)); end
      if (k == 1) src_valid = 1'b0;
    end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_idle: got %b expected 0", busy); end
    tick();
    n_compared++;
    if (push_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_after: got %b expected 0", push_out); end
  endtask

  // Pause alternates every cycle; a small occupancy model predicts pushes.
  task automatic test_pause_toggle();
    logic [5:0] words [8];
    int idx, pop_idx, mc;
    logic pause_now, exp_push, acc;
    words[0] = 6'h21; words[1] = 6'h02; words[2] = 6'h33; words[3] = 6'h04;
    words[4] = 6'h25; words[5] = 6'h16; words[6] = 6'h37; words[7] = 6'h08;
    idx = 0; pop_idx = 0; mc = 0;
    n_compared++;
    if (cnt_vc0 !== 8'd5 || cnt_vc1 !== 8'd1) begin n_mismatched++; $display("[TB] FAIL toggle_base_cnt: got %0d/%0d expected 5/1", cnt_vc0, cnt_vc1); end
    for (int cyc = 0; cyc < 60 && pop_idx < 8; cyc++) begin
      main_pause = cyc[0];
      pause_now  = cyc[0];
      src_valid  = (idx < 8);
      src_data   = (idx < 8) ? words[idx] : 6'h00;
      exp_push   = (mc > 0) && !pause_now;
      acc        = src_valid && (mc != 4);
      n_compared++;
      if (src_ready !== (mc != 4)) begin n_mismatched++; $display("[TB] FAIL toggle_ready_c%0d: got %b expected %b", cyc, src_ready, (mc != 4)); end
      tick();
      n_compared++;
      if (push_out !== exp_push) begin n_mismatched++; $display("[TB] FAIL toggle_push_c%0d: got %b expected %b", cyc, push_out, exp_push); end
      if (exp_push) begin
        n_compared++;
        if (data_out !== words[pop_idx]) begin n_mismatched++; $display("[TB] FAIL toggle_order_%0d: got %h expected %h", pop_idx, data_out, words[pop_idx]); end
        pop_idx++;
      end
      mc = mc + (acc ? 1 : 0) - (exp_push ? 1 : 0);
      if (acc) idx++;
    end
    src_valid  = 1'b0;
    main_pause = 1'b0;
    n_compared++;
    if (pop_idx != 8) begin n_mismatched++; $display("[TB] FAIL toggle_timeout: got %0d pushes expected 8", pop_idx); end
    n_compared++;
    if (cnt_vc0 !== 8'd9 || cnt_vc1 !== 8'd5) begin n_mismatched++; $display("[TB] FAIL toggle_cnt: got %0d/%0d expected 9/5", cnt_vc0, cnt_vc1); end
  endtask

  // CNT_W=3 instance: ten VC0 words at full rate, counter sticks at 7.
  task automatic test_saturation();
    int pushes;
    pushes = 0;
    for (int i = 0; i < 14; i++) begin
      sat_valid = (i < 10);
      sat_data  = 6'(i % 16);
      tick();
      if (sat_push) begin
        pushes++;
        if (pushes == 7) begin
          n_compared++;
          if (sat_cnt_vc0 !== 3'd7) begin n_mismatched++; $display("[TB] FAIL sat_reach7: got %0d expected 7", sat_cnt_vc0); end
        end
      end
    end
    sat_valid = 1'b0;
    n_compared++;
    if (sat_cnt_vc0 !== 3'd7 || sat_cnt_vc1 !== 3'd0) begin n_mismatched++; $display("[TB] FAIL sat_hold: got %0d/%0d expected 7/0", sat_cnt_vc0, sat_cnt_vc1); end
    n_compared++;
    if (pushes != 10) begin n_mismatched++; $display("[TB] FAIL sat_pushes: got %0d expected 10", pushes); end
  endtask

  // Synchronous init with 3 queued words, then asynchronous reset mid-burst.
  task automatic test_flush();
    main_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1;
      src_data  = 6'(8'h11 + i);
      tick();
    end
    src_valid  = 1'b0;
    main_pause = 1'b0;
    init       = 1'b1;
    #1;
    n_compared++;
    if (src_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_ready_init: got %b expected 0", src_ready); end
    tick();
    init = 1'b0;
    n_compared++;
    if (push_out !== 1'b0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_init: got push=%b busy=%b expected 0/0", push_out, busy); end
    n_compared++;
    if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin n_mismatched++; $display("[TB] FAIL flush_cnt: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
    tick();
    n_compared++;
    if (push_out !== 1'b0 || src_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_empty: got push=%b ready=%b expected 0/1", push_out, src_ready); end

    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = 6'(8'h01 + i);
      tick();
    end
    n_compared++;
    if (push_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL burst_active: got %b expected 1", push_out); end
    #2 reset_L = 1'b0;
    #1;
    src_valid = 1'b0;
    n_compared++;
    if (push_out !== 1'b0 || busy !== 1'b0 || data_out !== 6'h00) begin n_mismatched++; $display("[TB] FAIL async_reset: got push=%b busy=%b data=%h expected 0/0/00", push_out, busy, data_out); end
    n_compared++;
    if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin n_mismatched++; $display("[TB] FAIL async_reset_cnt: got %0d/%0d expected 0/0", cnt_vc0, cnt_vc1); end
    tick();
    #3 reset_L = 1'b1;
    tick();
    tick();
    n_compared++;
    if (push_out !== 1'b0 || busy !== 1'b0 || src_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_discard: got push=%b busy=%b ready=%b expected 0/0/1", push_out, busy, src_ready); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_pause_toggle();
    test_saturation();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
